credit_sender: RTL and testbench

Credit-gated, round-robin packet sender that sits directly upstream of the output queue. It arbitrates among `NUM_SRC` packet sources and loads at most one packet per cycle into a one-entry output register that drives the queue's enqueue interface. It holds one credit per queue slot, spends a credit on every packet it commits, and regains one on each `credit_return` pulse. As a result, the downstream queue can never overflow.

---
 rtl/credit_sender.sv | 184 ++++++++++++++++++
 tb/tb_credit_sender.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/credit_sender.sv
// ---------------------------------------------------------------------------
// credit_sender
//   Credit-gated round-robin packet sender feeding a downstream queue through
//   a one-entry output register. One credit is held per downstream slot, one
//   is spent per committed packet, and one is regained per credit_return
//   pulse, so the downstream queue cannot overflow.
//
// Ports
//   clk             : clock, rising edge
//   rst             : synchronous active-high reset
//   src_valid       : per-source packet valid             [NUM_SRC]
//   src_data        : per-source packets, source i at [i*PACKET_WIDTH +: PACKET_WIDTH]
//   src_ready       : one-hot/zero accept strobe (combinational)
//   pkt_valid       : output register holds a packet (queue enq_valid)
//   pkt_data        : output register contents (queue enq_data)
//   pkt_ready       : downstream accepts (queue enq_ready)
//   credit_return   : one-cycle pulse, one downstream slot freed
//   credit_count    : current credit count
//   grant_idx       : index of the last source loaded
//   credit_overflow : sticky, a return arrived with credits already full
// ---------------------------------------------------------------------------
module credit_sender #(
    parameter int unsigned PACKET_WIDTH = 128,
    parameter int unsigned NUM_SRC      = 4,
    parameter int unsigned CREDITS      = 8,
    localparam int unsigned CW          = $clog2(CREDITS + 1),
    localparam int unsigned IW          = $clog2(NUM_SRC)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SRC-1:0]              src_valid,
    input  logic [NUM_SRC*PACKET_WIDTH-1:0] src_data,
    output logic [NUM_SRC-1:0]              src_ready,
    output logic                            pkt_valid,
    output logic [PACKET_WIDTH-1:0]         pkt_data,
    input  logic                            pkt_ready,
    input  logic                            credit_return,
    output logic [CW-1:0]                   credit_count,
    output logic [IW-1:0]                   grant_idx,
    output logic                            credit_overflow
);

    // Output register occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [PACKET_WIDTH-1:0] r_pkt_data;
    logic [IW-1:0]           r_grant_idx;
    logic [IW-1:0]           r_rr_ptr;
    logic [CW-1:0]           r_credit_count;
    logic                    r_credit_overflow;

    logic                    w_drain;
    logic                    w_free;
    logic                    w_has_credit;
    logic                    w_found;
    logic [IW-1:0]           w_winner;
    logic [IW-1:0]           w_rr_nxt;
    logic                    w_load;
    logic [PACKET_WIDTH-1:0] w_sel_data;
    logic [CW-1:0]           w_credit_nxt;
    logic                    w_ovf_set;

    // (base + ofs) mod NUM_SRC for ofs < NUM_SRC; valid for non-power-of-two counts
    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base,
                                               input int unsigned   ofs);
        int unsigned s;
        s = 32'(base) + ofs;
        if (s >= NUM_SRC) begin
            s = s - NUM_SRC;
        end
        return IW'(s);
    endfunction

    // Handshake qualifiers
    assign w_drain      = (r_state == ST_FULL) & pkt_ready;
    assign w_free       = (r_state == ST_EMPTY) | w_drain;
    assign w_has_credit = (r_credit_count != '0);

    // Round-robin search: first requester at or after the priority pointer
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (!w_found && src_valid[wrap_idx(r_rr_ptr, k)]) begin
                w_found  = 1'b1;
                w_winner = wrap_idx(r_rr_ptr, k);
            end
        end
    end

    // Only the registered count gates a load; a same-cycle return cannot help
    assign w_load    = ~rst & w_free & w_has_credit & w_found;
    assign src_ready = w_load ? (NUM_SRC'(1) << w_winner) : '0;

    assign w_rr_nxt  = (w_winner == IW'(NUM_SRC - 1)) ? '0 : (w_winner + IW'(1));

    // Winner data mux
    always_comb begin
        w_sel_data = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (IW'(i) == w_winner) begin
                w_sel_data = src_data[i*PACKET_WIDTH +: PACKET_WIDTH];
            end
        end
    end

    // Credit arithmetic: load spends, return refunds, saturate at CREDITS
    always_comb begin
        w_credit_nxt = r_credit_count;
        w_ovf_set    = 1'b0;
        unique case ({w_load, credit_return})
            2'b10: w_credit_nxt = r_credit_count - CW'(1);
            2'b01: begin
                if (r_credit_count == CW'(CREDITS)) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_credit_nxt = r_credit_count + CW'(1);
                end
            end
            default: w_credit_nxt = r_credit_count;
        endcase
    end

    // Occupancy next-state
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_load) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_drain && !w_load) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Occupancy state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath, arbitration pointer and credit registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_data        <= '0;
            r_grant_idx       <= '0;
            r_rr_ptr          <= '0;
            r_credit_count    <= CW'(CREDITS);
            r_credit_overflow <= 1'b0;
        end else begin
            if (w_load) begin
                r_pkt_data  <= w_sel_data;
                r_grant_idx <= w_winner;
                r_rr_ptr    <= w_rr_nxt;
            end
            r_credit_count <= w_credit_nxt;
            if (w_ovf_set) begin
                r_credit_overflow <= 1'b1;
            end
        end
    end

    assign pkt_valid       = (r_state == ST_FULL);
    assign pkt_data        = r_pkt_data;
    assign grant_idx       = r_grant_idx;
    assign credit_count    = r_credit_count;
    assign credit_overflow = r_credit_overflow;

endmodule

// File: tb/tb_credit_sender.sv
// ---------------------------------------------------------------------------
// tb_credit_sender
//   Scoreboard bench for credit_sender. Sources are per-source packet queues;
//   a reference model (credit counter, rotating priority, scoreboard
//   occupancy) predicts each accepted packet and pushes it to the scoreboard;
//   an independent monitor pops and compares whenever the DUT shows a packet.
// ---------------------------------------------------------------------------
module tb_credit_sender;

    localparam int unsigned PW  = 128;
    localparam int unsigned NS  = 4;
    localparam int unsigned CR  = 8;
    localparam int unsigned CWL = $clog2(CR + 1);
    localparam int unsigned IWL = $clog2(NS);

    logic              clk;
    logic              rst;
    logic [NS-1:0]     src_valid;
    logic [NS*PW-1:0]  src_data;
    logic [NS-1:0]     src_ready;
    logic              pkt_valid;
    logic [PW-1:0]     pkt_data;
    logic              pkt_ready;
    logic              credit_return;
    logic [CWL-1:0]    credit_count;
    logic [IWL-1:0]    grant_idx;
    logic              credit_overflow;

    credit_sender #(.PACKET_WIDTH(PW), .NUM_SRC(NS), .CREDITS(CR)) dut (
        .clk             (clk),
        .rst             (rst),
        .src_valid       (src_valid),
        .src_data        (src_data),
        .src_ready       (src_ready),
        .pkt_valid       (pkt_valid),
        .pkt_data        (pkt_data),
        .pkt_ready       (pkt_ready),
        .credit_return   (credit_return),
        .credit_count    (credit_count),
        .grant_idx       (grant_idx),
        .credit_overflow (credit_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [PW-1:0] data;
        int unsigned   idx;
    } exp_t;

    exp_t          sb [$];
    logic [PW-1:0] srcq [NS][$];

    int            n_tests = 0;
    int            n_fail  = 0;

    // Reference model state
    int            m_credits = CR;
    int unsigned   m_rr      = 0;
    logic          m_ovf     = 1'b0;
    logic [NS-1:0] last_ready;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] rnd_pkt();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic clear_sources();
        for (int i = 0; i < NS; i++) srcq[i].delete();
    endtask

    // One cycle: drive at negedge+1, predict and check at negedge+3
    task automatic step(input logic r, input logic pr, input logic cr);
        logic          load;
        logic          any;
        int unsigned   win;
        logic [NS-1:0] exp_ready;
        @(negedge clk);
        #1;
        rst           = r;
        pkt_ready     = pr;
        credit_return = cr;
        for (int i = 0; i < NS; i++) begin
            src_valid[i]          = (srcq[i].size() > 0);
            src_data[i*PW +: PW]  = (srcq[i].size() > 0) ? srcq[i][0] : '0;
        end
        #2;
        // The monitor has already retired a draining packet, so an empty
        // scoreboard means the output slot is free this cycle.
        any = 1'b0;
        win = 0;
        for (int k = 0; k < NS; k++) begin
            int unsigned p;
            p = (m_rr + k) % NS;
            if (!any && srcq[p].size() > 0) begin
                any = 1'b1;
                win = p;
            end
        end
        load      = !r && (sb.size() == 0) && (m_credits > 0) && any;
        exp_ready = load ? NS'(1 << win) : '0;
        chk("src_ready", PW'(src_ready), PW'(exp_ready));
        chk("credit_count", PW'(credit_count), PW'(m_credits));
        chk("credit_overflow", PW'(credit_overflow), PW'(m_ovf));
        last_ready = src_ready;
        if (r) begin
            sb.delete();
            m_credits = CR;
            m_rr      = 0;
            m_ovf     = 1'b0;
        end else begin
            if (load) begin
                exp_t e;
                e.data = srcq[win][0];
                e.idx  = win;
                sb.push_back(e);
                void'(srcq[win].pop_front());
                m_rr = (win + 1) % NS;
            end
            m_credits = m_credits - (load ? 1 : 0) + (cr ? 1 : 0);
            if (m_credits > CR) begin
                m_credits = CR;
                m_ovf     = 1'b1;
            end
        end
    endtask

    // Monitor: compare the output register against the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                chk("pkt_valid", PW'(pkt_valid), PW'(sb.size() > 0));
                if (sb.size() > 0) begin
                    chk("pkt_data", pkt_data, sb[0].data);
                    chk("grant_idx", PW'(grant_idx), PW'(sb[0].idx));
                    if (pkt_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        int            cnt;
        logic [PW-1:0] pa;
        rst           = 1'b1;
        pkt_ready     = 1'b0;
        credit_return = 1'b0;
        src_valid     = '0;
        src_data      = '0;
        last_ready    = '0;

        // Reset values, then idle release
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        chk("rst_pkt_valid", PW'(pkt_valid), '0);
        chk("rst_credit", PW'(credit_count), PW'(CR));
        chk("rst_grant_idx", PW'(grant_idx), '0);
        chk("rst_overflow", PW'(credit_overflow), '0);
        step(0, 0, 0);

        // Round-robin with a return every cycle
        for (int i = 0; i < NS; i++)
            for (int j = 0; j < 6; j++) srcq[i].push_back(rnd_pkt());
        for (int k = 0; k < 16; k++) begin
            step(0, 1, 1);
            chk("rr_order", PW'(last_ready), PW'(1 << (k % NS)));
        end

        // Credit exhaustion on source 2
        step(1, 1, 0);
        clear_sources();
        step(1, 1, 0);
        for (int j = 0; j < 20; j++) srcq[2].push_back(rnd_pkt());
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            step(0, 1, 0);
            if (last_ready[2]) cnt++;
        end
        chk("exhaust_loads", PW'(cnt), PW'(CR));
        chk("exhaust_credit", PW'(credit_count), '0);
        step(0, 1, 1);
        chk("exhaust_no_load", PW'(last_ready), '0);
        step(0, 1, 0);
        chk("refund_credit", PW'(credit_count), PW'(1));
        chk("refund_load", PW'(last_ready), PW'(4'b0100));
        step(0, 1, 0);
        chk("refund_only_one", PW'(last_ready), '0);

        // Downstream stall holds packet and pointer
        step(1, 0, 0);
        clear_sources();
        step(1, 0, 0);
        pa = rnd_pkt();
        srcq[0].push_back(pa);
        step(0, 0, 0);
        for (int i = 1; i < NS; i++) srcq[i].push_back(rnd_pkt());
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0);
            chk("stall_data", pkt_data, pa);
            chk("stall_ready", PW'(last_ready), '0);
        end
        step(0, 1, 0);
        chk("stall_release", PW'(last_ready), PW'(4'b0010));

        // Mid-stream reset with 3 credits left and a packet held
        step(1, 0, 0);
        clear_sources();
        step(1, 0, 0);
        for (int j = 0; j < 10; j++) srcq[3].push_back(rnd_pkt());
        for (int k = 0; k < 5; k++) step(0, 1, 0);
        step(1, 0, 0);
        chk("mid_credit_before", PW'(credit_count), PW'(3));
        chk("mid_valid_before", PW'(pkt_valid), PW'(1));
        for (int i = 0; i < 3; i++) srcq[i].push_back(rnd_pkt());
        step(0, 1, 0);
        chk("mid_valid_after", PW'(pkt_valid), '0);
        chk("mid_credit_after", PW'(credit_count), PW'(CR));
        chk("mid_first_winner", PW'(last_ready), PW'(4'b0001));

        // Overflow is sticky until reset
        step(1, 0, 0);
        clear_sources();
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        chk("ovf_set", PW'(credit_overflow), PW'(1));
        chk("ovf_credit_sat", PW'(credit_count), PW'(CR));
        for (int k = 0; k < 3; k++) step(0, 1, 0);
        chk("ovf_sticky", PW'(credit_overflow), PW'(1));
        step(1, 0, 0);
        step(0, 0, 0);
        chk("ovf_cleared", PW'(credit_overflow), '0);

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < NS; i++)
                if (srcq[i].size() < 3 && $urandom_range(1, 0) == 1) srcq[i].push_back(rnd_pkt());
            step(($urandom_range(199, 0) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(3, 0) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(2, 0) == 0) ? 1'b1 : 1'b0);
        end

        @(negedge clk);
        #4;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
